// File: rtl/beep_pkg.sv
// beep_pkg: state encoding and cycle/width helpers shared by the beep driver.
package beep_pkg;

   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

   // 64-bit intermediate: ON_US * CLK_HZ overflows 32 bits at default settings.
   function automatic int unsigned us_to_cyc(input longint unsigned us, input longint unsigned clk_hz);
      return 32'(us * clk_hz / 64'd1_000_000);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/beep_driver_tone_gen.sv
// tone_gen: square wave starting high, toggling every HALF cycles while enabled.
module tone_gen
   import beep_pkg::*;
#(
   parameter int unsigned HALF = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic sq
);

   localparam int unsigned HW = cnt_w(HALF);
   localparam logic [HW-1:0] H_LAST = HW'(HALF - 1);

   logic [HW-1:0] hc;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sq <= 1'b0;
         hc <= '0;
      end else if (!en || restart) begin
         sq <= en;
         hc <= '0;
      end else if (hc == H_LAST) begin
         sq <= ~sq;
         hc <= '0;
      end else
         hc <= hc + 1'b1;

endmodule

// File: rtl/beep_driver.sv
// beep_driver: queues request pulses and plays each as a tone burst plus LED, then a silent gap.
module beep_driver
   import beep_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 1_000_000,
   parameter int unsigned TONE_HZ = 2000,
   parameter int unsigned ON_US   = 100000,
   parameter int unsigned OFF_US  = 50000,
   parameter int unsigned PEND_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beep_req,
   output logic              buzzer_out,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              drop
);

   localparam int unsigned HALF    = CLK_HZ / (2 * TONE_HZ);
   localparam int unsigned ON_CYC  = us_to_cyc(ON_US, CLK_HZ);
   localparam int unsigned OFF_CYC = us_to_cyc(OFF_US, CLK_HZ);
   localparam int unsigned CW      = cnt_w(ON_CYC) > cnt_w(OFF_CYC) ? cnt_w(ON_CYC) : cnt_w(OFF_CYC);
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
   localparam logic [PEND_W-1:0] MAXP = '1;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [PEND_W-1:0] pend_nx;
   logic              launch, drop_nx;

   always_comb begin
      launch   = (state == IDLE || (state == GAP && cnt == OFF_LAST)) && (pending != '0 || beep_req);
      state_nx = launch                         ? ON   :
                 state == ON  && cnt == ON_LAST  ? GAP  :
                 state == GAP && cnt == OFF_LAST ? IDLE : state;
      // A request arriving on a launch cycle cancels the pending decrement.
      pend_nx  = launch                       ? (beep_req ? pending : pending - 1'b1) :
                 beep_req && pending != MAXP  ? pending + 1'b1 : pending;
      drop_nx  = !launch && beep_req && pending == MAXP;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         pending <= '0;
         drop    <= 1'b0;
         led_out <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
         pending <= pend_nx;
         drop    <= drop_nx;
         led_out <= state_nx == ON;
         busy    <= state_nx != IDLE;
      end

   tone_gen #(.HALF(HALF)) u_tone (
      .clk     (clk),
      .rst     (rst),
      .en      (state_nx == ON),
      .restart (launch),
      .sq      (buzzer_out)
   );

endmodule

// File: doc/beep_driver.md
Name: beep_driver

Overview:
- Converts clean single-cycle event pulses into a timed audible/visible indication: a tone burst on the buzzer pin plus an LED level, followed by a silent gap.
- Sits downstream of the button-conditioning logic, on the output side of the panel I/O.
- Queues requests that arrive while a beep is in progress and plays them back-to-back.
- Runs on the 1 MHz system clock.

Parameters:
- CLK_HZ, 1_000_000, system clock frequency in Hz.
- TONE_HZ, 2000, buzzer tone frequency; HALF = CLK_HZ/(2*TONE_HZ) cycles per half-period; HALF >= 1 is required.
- ON_US, 100000, beep length in microseconds; ON_CYC = ON_US*CLK_HZ/1_000_000; ON_CYC >= 1 is required.
- OFF_US, 50000, gap after each beep; OFF_CYC derived the same way; OFF_CYC >= 1 is required.
- PEND_W, 3, pending-counter width; MAXP = 2**PEND_W - 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- beep_req  in  1  one-cycle request pulse, already synchronous to clk.
- buzzer_out  out  1  square-wave tone during ON, 0 otherwise.
- led_out  out  1  1 exactly while state is ON.
- busy  out  1  1 whenever state is not IDLE.
- pending  out  PEND_W  queued, not-yet-started beeps.
- drop  out  1  one-cycle pulse when a request is discarded at saturation.

Behaviour:
- Reset: while rst is high, all state and outputs go to 0 asynchronously: state=IDLE, pending=0, buzzer_out=0, led_out=0, busy=0, drop=0, all counters 0. The same applies when rst is asserted mid-ON or mid-GAP.
- FSM states: IDLE, ON, GAP. Registered outputs are decoded from state.
- Launch condition L, evaluated in IDLE and on the last GAP cycle: L = (pending != 0) || beep_req.
- IDLE, L true: the next edge enters ON and zeroes the duration counter.
- Pending accounting on a launch:
  - beep_req=1 and pending=0: the request is consumed directly; pending stays 0.
  - beep_req=0 and pending>0: pending decrements by 1.
  - beep_req=1 and pending>0: pending is unchanged (+1 and -1 cancel).
- Pending accounting in all other cycles: beep_req=1 increments pending.
- Saturation: beep_req=1 with pending=MAXP and no launch that cycle discards the request, leaves pending at MAXP, and asserts drop for 1 cycle.
- ON lasts exactly ON_CYC cycles, then enters GAP.
- GAP lasts exactly OFF_CYC cycles. On its last cycle, L true goes directly to ON with no IDLE cycle in between; otherwise the next state is IDLE.
- Tone:
  - buzzer_out is 1 in the first ON cycle and toggles every HALF cycles.
  - The phase restarts at each ON entry.
  - buzzer_out is forced to 0 in IDLE and GAP.
- Latency: a beep_req sampled at edge N, with state IDLE, gives led_out=1 from edge N onward.
- Back-to-back beep period: ON_CYC+OFF_CYC.
- Counter widths come from $clog2 of ON_CYC, OFF_CYC and HALF. Counters never wrap; they are cleared on every state change.

Decomposition:
- Package beep_pkg holds:
  - the state enum (IDLE, ON, GAP);
  - a function us_to_cyc(us, clk_hz) returning cycle counts;
  - localparam helpers for the counter widths.
- One natural sub-module, tone_gen:
  - inputs: clk, rst, en, restart;
  - output: sq;
  - contains the half-period counter;
  - sq=0 when en=0.

Test Plan (CLK_HZ=1_000_000, TONE_HZ=100_000 → HALF=5, ON_US=20, OFF_US=10, PEND_W=3):
- Single request: beep_req pulse sampled at edge 10 → led_out=1 for edges 10..29; buzzer_out 1,1,1,1,1,0,0,0,0,0 repeated twice; GAP for edges 30..39; busy=0 from edge 40; pending stays 0.
- Burst of 3: requests on 3 consecutive cycles from idle → pending goes 0,1,2. ON bursts start at edges T, T+30, T+60, with pending 1 after the second launch and 0 after the third. busy drops at T+90.
- Saturation: 9 requests during one ON → pending reaches 7; drop pulses on the 8th and 9th requests; exactly 8 beeps follow.
- Simultaneous events: beep_req on the last GAP cycle with pending=1 → the next edge enters ON with no IDLE cycle; pending stays 1.
- Request during GAP with pending=0: the request is queued as pending=1 → ON begins right after GAP, and pending returns to 0.
- Reset mid-ON: rst asserted at ON cycle 7 with pending=3 → buzzer_out, led_out, busy and pending all read 0 before the next clock edge; after release, no beep occurs without a new request.
